board_ram_scheduler: RTL

//  Time-shares the single synchronous read port of the board-state RAM between
//  the video line prefetcher (internal) and game-logic reads (req/gnt client).

---
 rtl/board_ram_scheduler.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/board_ram_scheduler.sv
// Shares the board-state RAM read port between the scanline prefetcher and game-logic reads.
// Rows for the next line are fetched into shadow buffers during blanking and swapped in at end of line.
module board_ram_scheduler #(
    parameter int unsigned DATA_W       = 30,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned V_START      = 40,
    parameter int unsigned V_END        = 424,
    parameter int unsigned CELL_SHIFT   = 4,
    parameter int unsigned PREVIEW_BASE = 24,
    parameter int unsigned H_FETCH      = 640,
    parameter int unsigned H_SWAP       = 799,
    parameter int unsigned V_MAX        = 524
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_readwire_i,
    input  logic [9:0]        v_readwire_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              game_req_i,
    input  logic [ADDR_W-1:0] game_addr_i,
    output logic              game_gnt_o,
    output logic [DATA_W-1:0] game_rdata_o,
    output logic              game_rdata_valid_o,
    output logic [DATA_W-1:0] board_row_o,
    output logic [DATA_W-1:0] preview_row_o,
    output logic              row_valid_o,
    output logic              fetch_miss_o
);

    localparam logic [9:0]        V_START_C    = 10'(V_START);
    localparam logic [9:0]        V_END_C      = 10'(V_END);
    localparam logic [9:0]        V_MAX_C      = 10'(V_MAX);
    localparam logic [9:0]        H_FETCH_C    = 10'(H_FETCH);
    localparam logic [9:0]        H_SWAP_C     = 10'(H_SWAP);
    localparam logic [ADDR_W-1:0] PREV_BASE_C  = ADDR_W'(PREVIEW_BASE);
    localparam logic [ADDR_W-1:0] PREVIEW_ROWS = ADDR_W'(4);

    typedef enum logic [2:0] {
        IDLE,
        FB_ISSUE,
        FB_CAP,
        FP_ISSUE,
        FP_CAP,
        G_ISSUE,
        G_CAP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_re_q, ram_re_d;
    logic              game_gnt_q, game_gnt_d;
    logic              game_valid_q, game_valid_d;
    logic [DATA_W-1:0] game_rdata_q, game_rdata_d;
    logic [DATA_W-1:0] shadow_board_q, shadow_board_d;
    logic [DATA_W-1:0] shadow_prev_q, shadow_prev_d;
    logic [DATA_W-1:0] board_row_q, board_row_d;
    logic [DATA_W-1:0] preview_row_q, preview_row_d;
    logic              row_valid_q, row_valid_d;
    logic              fetch_miss_q, fetch_miss_d;
    logic              fetch_pend_q, fetch_pend_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] row_q, row_d;

    // Raster decode for the line that follows the current one
    logic [9:0]        v_next;
    logic [9:0]        row_full;
    logic [ADDR_W-1:0] row_idx;
    logic              in_region;
    logic              trig;
    logic              swap;
    logic              miss_now;
    logic              unused_row_bits;

    assign v_next          = (v_readwire_i == V_MAX_C) ? 10'd0 : v_readwire_i + 10'd1;
    assign in_region       = (v_next >= V_START_C) && (v_next < V_END_C);
    assign row_full        = (v_next - V_START_C) >> CELL_SHIFT;
    assign row_idx         = row_full[ADDR_W-1:0];
    assign unused_row_bits = ^row_full[9:ADDR_W];
    assign trig            = (h_readwire_i == H_FETCH_C) && in_region;
    assign swap            = (h_readwire_i == H_SWAP_C);
    assign miss_now        = swap && in_region && !done_q;

    // FSM: registered RAM controls are loaded on entry to each issue state
    logic start_fetch;
    logic fetch_done;
    logic prev_zero;

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_re_d     = 1'b0;
        game_gnt_d   = 1'b0;
        game_valid_d = 1'b0;
        start_fetch  = 1'b0;
        fetch_done   = 1'b0;
        prev_zero    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_pend_q || trig) begin
                    state_d     = FB_ISSUE;
                    ram_addr_d  = trig ? row_idx : row_q;
                    ram_re_d    = 1'b1;
                    start_fetch = 1'b1;
                end else if (game_req_i) begin
                    state_d    = G_ISSUE;
                    ram_addr_d = game_addr_i;
                    ram_re_d   = 1'b1;
                    game_gnt_d = 1'b1;
                end
            end
            FB_ISSUE: state_d = FB_CAP;
            FB_CAP: begin
                if (row_q < PREVIEW_ROWS) begin
                    state_d    = FP_ISSUE;
                    ram_addr_d = PREV_BASE_C + row_q;
                    ram_re_d   = 1'b1;
                end else begin
                    state_d    = IDLE;
                    fetch_done = 1'b1;
                    prev_zero  = 1'b1;
                end
            end
            FP_ISSUE: state_d = FP_CAP;
            FP_CAP: begin
                state_d    = IDLE;
                fetch_done = 1'b1;
            end
            G_ISSUE: begin
                state_d      = G_CAP;
                game_valid_d = 1'b1;
            end
            G_CAP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A late prefetch is abandoned at swap; game reads in flight are never cut
        if (miss_now && (state_d inside {FB_ISSUE, FB_CAP, FP_ISSUE, FP_CAP})) begin
            state_d     = IDLE;
            ram_addr_d  = ram_addr_q;
            ram_re_d    = 1'b0;
            start_fetch = 1'b0;
        end
    end

    always_comb begin
        shadow_board_d = shadow_board_q;
        shadow_prev_d  = shadow_prev_q;
        board_row_d    = board_row_q;
        preview_row_d  = preview_row_q;
        row_valid_d    = row_valid_q;
        fetch_miss_d   = fetch_miss_q;
        fetch_pend_d   = fetch_pend_q;
        done_d         = done_q;
        row_d          = row_q;
        game_rdata_d   = game_rdata_q;

        if (state_q == FB_CAP) shadow_board_d = ram_rdata_i;
        if (state_q == FP_CAP) shadow_prev_d  = ram_rdata_i;
        if (prev_zero)         shadow_prev_d  = '0;
        if (fetch_done)        done_d         = 1'b1;
        if (state_q == G_CAP)  game_rdata_d   = ram_rdata_i;

        if (swap) begin
            done_d = 1'b0;
            if (!in_region) begin
                board_row_d   = '0;
                preview_row_d = '0;
                row_valid_d   = 1'b0;
            end else if (done_q) begin
                board_row_d   = shadow_board_q;
                preview_row_d = shadow_prev_q;
                row_valid_d   = 1'b1;
            end else begin
                fetch_miss_d = 1'b1;
                row_valid_d  = 1'b1;
            end
        end

        // Swap is resolved before a coincident trigger re-arms the prefetch
        if (miss_now)    fetch_pend_d = 1'b0;
        if (trig) begin
            fetch_pend_d = 1'b1;
            row_d        = row_idx;
        end
        if (start_fetch) fetch_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ram_addr_q     <= '0;
            ram_re_q       <= 1'b0;
            game_gnt_q     <= 1'b0;
            game_valid_q   <= 1'b0;
            game_rdata_q   <= '0;
            shadow_board_q <= '0;
            shadow_prev_q  <= '0;
            board_row_q    <= '0;
            preview_row_q  <= '0;
            row_valid_q    <= 1'b0;
            fetch_miss_q   <= 1'b0;
            fetch_pend_q   <= 1'b0;
            done_q         <= 1'b0;
            row_q          <= '0;
        end else begin
            state_q        <= state_d;
            ram_addr_q     <= ram_addr_d;
            ram_re_q       <= ram_re_d;
            game_gnt_q     <= game_gnt_d;
            game_valid_q   <= game_valid_d;
            game_rdata_q   <= game_rdata_d;
            shadow_board_q <= shadow_board_d;
            shadow_prev_q  <= shadow_prev_d;
            board_row_q    <= board_row_d;
            preview_row_q  <= preview_row_d;
            row_valid_q    <= row_valid_d;
            fetch_miss_q   <= fetch_miss_d;
            fetch_pend_q   <= fetch_pend_d;
            done_q         <= done_d;
            row_q          <= row_d;
        end
    end

    assign ram_addr_o         = ram_addr_q;
    assign ram_re_o           = ram_re_q;
    assign game_gnt_o         = game_gnt_q;
    assign game_rdata_valid_o = game_valid_q;
    // The RAM output register supplies the data in the valid cycle; the held copy follows
    assign game_rdata_o       = game_valid_q ? ram_rdata_i : game_rdata_q;
    assign board_row_o        = board_row_q;
    assign preview_row_o      = preview_row_q;
    assign row_valid_o        = row_valid_q;
    assign fetch_miss_o       = fetch_miss_q;

endmodule
